mcycle_unit: RTL
================

# mcycle_unit

Iterative multi-cycle execution unit for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), placed in the Execute stage alongside the ALU. It accepts operands when the decoded instruction reaches E and raises `Busy`. The hazard unit turns `Busy` into stalls of F/D/E, so the multiply/divide instruction stays in E until the result is ready. Shift-add multiplication and restoring division, one bit per cycle.

## Interface
- `WIDTH`, default 32, operand/result width in bits
- `CLK`  in  1  rising-edge clock
- `RESETn`  in  1  asynchronous, active-low reset
- `Start`  in  1  E-stage instruction is an M-extension op; level, held high while the instruction sits in E
- `MCycleOp`  in  3  instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `Operand1`  in  WIDTH  rs1 value (post-forwarding)
- `Operand2`  in  WIDTH  rs2 value (post-forwarding)
- `Result`  out  WIDTH  selected result, registered
- `Busy`  out  1  to hazard unit; stall E and earlier stages
- `Done`  out  1  one-cycle pulse; `Result` valid

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE, `Start`=1:
  - Capture the op and operand magnitudes.
    - Signed operands are MUL* rs1 for MULH/MULHSU, rs2 for MULH only, and both operands for DIV/REM.
    - MUL treats operands as unsigned, because the low word is sign-agnostic.
  - Record the result sign flag, clear the iteration counter, and go to COMPUTE.
- COMPUTE: one iteration per cycle; the counter runs 0..WIDTH-1. On the last iteration, load `Result` and go to DONE.
  - Multiply: 2·WIDTH accumulator with shift-add over the multiplier LSB.
  - Divide: restoring division. Shift {rem, quot} left, trial-subtract the divisor magnitude, and set the quotient bit if there is no borrow.
- Sign fix, applied when `Result` is loaded:
  - Product: negate the 2·WIDTH product if the operand signs differ.
    - MUL returns the low WIDTH bits.
    - MULH* return the high WIDTH bits.
  - Quotient: negate if the signs differ AND the divisor ≠ 0.
  - Remainder: takes the sign of the dividend.
- Divisor = 0 (all div/rem ops):
  - quotient = all ones.
  - remainder = original `Operand1`.
  - No sign correction on the quotient.
- Overflow (DIV/REM, `Operand1` = 0x8000_0000, `Operand2` = -1):
  - quotient = 0x8000_0000, remainder = 0.
  - The magnitude datapath yields this naturally; it must not be special-cased incorrectly.
- DONE: `Done`=1, `Busy`=0. Always go to IDLE next cycle. `Start` is ignored here, because the same instruction leaves E this cycle.
- IDLE, `Start`=0: hold; `Result` keeps its last value.
- `MCycleOp` and operands are only sampled at acceptance; later changes during COMPUTE are ignored.

## Timing
- `Busy` = (state==COMPUTE) | (state==IDLE & `Start`).
  - The IDLE term is combinational, so the stall begins in the same cycle the instruction enters E.
- Cycle 0 = acceptance. COMPUTE occupies cycles 1..WIDTH. DONE is cycle WIDTH+1.
- `Busy` is high for exactly WIDTH+1 consecutive cycles (cycles 0..WIDTH).
- `Done` and valid `Result` appear in cycle WIDTH+1. Latency is 33 cycles at WIDTH=32.
- `Result` is registered and stable from DONE until the next acceptance loads it again.
- Back-to-back ops:
  - A new `Start` can be accepted no earlier than the cycle after DONE (IDLE), so minimum spacing is WIDTH+2 cycles.
  - `Start` high in DONE never retriggers.
- Reset (`RESETn`=0, any time including mid-COMPUTE):
  - Immediately, asynchronously: state=IDLE, `Result`=0, `Done`=0, internal registers and counter cleared.
  - `Busy` = `Start` via the IDLE term, so hold `Start` low during reset.
  - Operation resumes on the first edge after `RESETn` rises.

## Test plan
- MUL 7 × 0xFFFF_FFFD (-3): `Busy` high 33 cycles from `Start`, `Done` pulse at cycle 33, `Result`=0xFFFF_FFEB.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000; MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD; REM -7 / 2 → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFF_FFFF, REM 5 / 0 → 5.
  - DIV -5 / 0 → 0xFFFF_FFFF, REM -5 / 0 → 0xFFFF_FFFB.
- Overflow DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM same operands → 0.
- `Start` held high through DONE → no second op, `Busy` low in DONE and the following IDLE cycle if `Start` drops.
- `RESETn` pulsed low at cycle 10 of a DIV → `Busy`=0 (`Start` low), `Done`=0, `Result`=0 immediately. A fresh DIVU 9 / 3 after release → 3 after 33 cycles.

Source files
------------

// File: rtl/mcycle_unit.sv
// RV32M iterative multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Busy stalls the pipeline from acceptance until Result is ready; Done pulses with it.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [2:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;
    logic               r_rneg;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

    logic               w_is_div;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    // Sign handling at acceptance: only the operands the op treats as signed are folded to magnitudes.
    assign w_is_div = MCycleOp[2];
    assign w_a_sgn  = w_is_div ? ~MCycleOp[0] : (MCycleOp == 3'b001 || MCycleOp == 3'b010);
    assign w_b_sgn  = w_is_div ? ~MCycleOp[0] : (MCycleOp == 3'b001);
    assign w_a_neg  = w_a_sgn & Operand1[WIDTH-1];
    assign w_b_neg  = w_b_sgn & Operand2[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -Operand1 : Operand1;
    assign w_b_mag  = w_b_neg ? -Operand2 : Operand2;
    assign w_b_zero = (Operand2 == '0);

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // Multiply: {hi, lo} with the multiplier in lo; add multiplicand to hi on lo[0], then shift right.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: {rem, quot} shifted left; the shifted remainder needs one extra bit for large divisors.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_new = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
    assign w_div_nxt = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;

    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_quot = r_neg ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_rem  = r_rneg ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res = w_prod[WIDTH-1:0];
        case (r_op)
            3'b000:                 w_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_res = w_quot;
            default:                w_res = w_rem;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_op   <= MCycleOp;
                        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b    <= w_b_mag;
                        // A zero divisor leaves the all-ones quotient uncorrected.
                        r_neg  <= (w_a_neg ^ w_b_neg) & (~w_is_div | ~w_b_zero);
                        r_rneg <= w_a_neg;
                        r_cnt  <= '0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy   = (r_state == S_COMPUTE) | ((r_state == S_IDLE) & Start);
    assign Done   = r_done;
    assign Result = r_result;

endmodule
